// File: rtl/pc_ctrl_unit.sv
// Program-counter controller for the fetch stage: sequential flow, RV32I branches,
// JAL/JALR, stall, misaligned-target trap and a FENCE drain state machine.
module pc_ctrl_unit #(
   parameter int              XLEN          = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR  = 'h0,
   parameter logic [XLEN-1:0] TRAP_VECTOR   = 'h10,
   parameter int              IALIGN        = 32,
   parameter int              FENCE_TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch,
   input  logic            jump,
   input  logic            jalr_sel,
   input  logic [2:0]      funct3,
   input  logic            zero,
   input  logic            less_than,
   input  logic            less_than_u,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] alu_target,
   input  logic            fence,
   input  logic            mem_idle,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] next_pc,
   output logic            taken,
   output logic            fence_busy,
   output logic            fence_timeout,
   output logic            misalign_trap,
   output logic [XLEN-1:0] predecessor,
   output logic [XLEN-1:0] successor
);

   localparam int              CW          = (FENCE_TIMEOUT > 1) ? $clog2(FENCE_TIMEOUT) : 1;
   localparam logic [CW-1:0]   CNT_LAST    = CW'(FENCE_TIMEOUT - 1);
   localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

   typedef enum logic {
      S_RUN,
      S_DRAIN
   } state_t;

   state_t          state_reg, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic [XLEN-1:0] pred_reg, pred_next;
   logic [XLEN-1:0] succ_reg, succ_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            trap_reg, trap_next;
   logic            tmo_reg, tmo_next;

   logic            cond;
   logic            taken_c;
   logic            misaligned;
   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] target;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000:  cond = zero;
         3'b001:  cond = ~zero;
         3'b100:  cond = less_than;
         3'b101:  cond = ~less_than;
         3'b110:  cond = less_than_u;
         3'b111:  cond = ~less_than_u;
         default: cond = 1'b0;
      endcase
   end

   // Redirects are suppressed while draining and on the fence instruction itself.
   assign taken_c = (jump | (branch & cond)) & ~fence & (state_reg == S_RUN);
   assign seq_pc  = pc_reg + INSTR_BYTES;

   always_comb begin
      target = seq_pc;
      if (jump && jalr_sel) begin
         target = {alu_target[XLEN-1:1], 1'b0};
      end else if (taken_c) begin
         target = pc_reg + imm;
      end
   end

   generate
      if (IALIGN == 16) begin : g_align16
         assign misaligned = taken_c & target[0];
      end else begin : g_align32
         assign misaligned = taken_c & (|target[1:0]);
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      pred_next  = pred_reg;
      succ_next  = succ_reg;
      cnt_next   = cnt_reg;
      trap_next  = 1'b0;
      tmo_next   = 1'b0;
      case (state_reg)
         S_RUN: begin
            if (!stall) begin
               if (fence) begin
                  pred_next  = pc_reg;
                  succ_next  = seq_pc;
                  cnt_next   = '0;
                  state_next = S_DRAIN;
               end else if (misaligned) begin
                  pc_next   = TRAP_VECTOR;
                  trap_next = 1'b1;
               end else begin
                  pc_next = target;
               end
            end
         end
         S_DRAIN: begin
            // Stall and new fences are ignored until the memory system drains.
            if (mem_idle) begin
               pc_next    = succ_reg;
               state_next = S_RUN;
            end else if (cnt_reg == CNT_LAST) begin
               pc_next    = succ_reg;
               tmo_next   = 1'b1;
               state_next = S_RUN;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: state_next = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_RUN;
         pc_reg    <= RESET_VECTOR;
         pred_reg  <= '0;
         succ_reg  <= '0;
         cnt_reg   <= '0;
         trap_reg  <= 1'b0;
         tmo_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         pred_reg  <= pred_next;
         succ_reg  <= succ_next;
         cnt_reg   <= cnt_next;
         trap_reg  <= trap_next;
         tmo_reg   <= tmo_next;
      end
   end

   assign pc_out        = pc_reg;
   assign next_pc       = seq_pc;
   assign taken         = taken_c;
   assign fence_busy    = (state_reg == S_DRAIN);
   assign fence_timeout = tmo_reg;
   assign misalign_trap = trap_reg;
   assign predecessor   = pred_reg;
   assign successor     = succ_reg;

endmodule

// File: tb/tb_pc_ctrl_unit.sv
// Bench for pc_ctrl_unit: two instances (IALIGN=32/timeout 64 and IALIGN=16/timeout 4)
// driven with the same stimulus and compared against a behavioural model.
module tb_pc_ctrl_unit;

   localparam logic [31:0] TRAP = 32'h10;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, branch, jump, jalr_sel, zero, less_than, less_than_u, fence, mem_idle;
   logic [2:0]  funct3;
   logic [31:0] imm, alu_target;

   logic [31:0] a_pc, a_next, a_pred, a_succ, b_pc, b_next, b_pred, b_succ;
   logic        a_taken, a_busy, a_tmo, a_trap, b_taken, b_busy, b_tmo, b_trap;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int busy_a_n, busy_b_n, tmo_a_n, tmo_b_n;

   always #5 clk = ~clk;

   pc_ctrl_unit #(.XLEN(32), .IALIGN(32), .FENCE_TIMEOUT(64)) dut_a (
      .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jump(jump),
      .jalr_sel(jalr_sel), .funct3(funct3), .zero(zero), .less_than(less_than),
      .less_than_u(less_than_u), .imm(imm), .alu_target(alu_target), .fence(fence),
      .mem_idle(mem_idle), .pc_out(a_pc), .next_pc(a_next), .taken(a_taken),
      .fence_busy(a_busy), .fence_timeout(a_tmo), .misalign_trap(a_trap),
      .predecessor(a_pred), .successor(a_succ)
   );

   pc_ctrl_unit #(.XLEN(32), .IALIGN(16), .FENCE_TIMEOUT(4)) dut_b (
      .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jump(jump),
      .jalr_sel(jalr_sel), .funct3(funct3), .zero(zero), .less_than(less_than),
      .less_than_u(less_than_u), .imm(imm), .alu_target(alu_target), .fence(fence),
      .mem_idle(mem_idle), .pc_out(b_pc), .next_pc(b_next), .taken(b_taken),
      .fence_busy(b_busy), .fence_timeout(b_tmo), .misalign_trap(b_trap),
      .predecessor(b_pred), .successor(b_succ)
   );

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] pred;
      logic [31:0] succ;
      bit          drain;
      int          waited;
      bit          trap;
      bit          tmo;
   } mstate_t;

   mstate_t ma, mb;

   function automatic mstate_t m_reset();
      mstate_t s;
      s.pc = 32'h0; s.pred = 32'h0; s.succ = 32'h0;
      s.drain = 1'b0; s.waited = 0; s.trap = 1'b0; s.tmo = 1'b0;
      return s;
   endfunction

   function automatic bit cond_met();
      case (funct3)
         3'b000:  return zero;
         3'b001:  return !zero;
         3'b100:  return less_than;
         3'b101:  return !less_than;
         3'b110:  return less_than_u;
         3'b111:  return !less_than_u;
         default: return 1'b0;
      endcase
   endfunction

   function automatic bit m_taken(mstate_t s);
      return !s.drain && !fence && (jump || (branch && cond_met()));
   endfunction

   function automatic mstate_t m_step(mstate_t s, int ialign, int limit);
      mstate_t     n;
      logic [31:0] tgt;
      bit          tk;
      n = s;
      n.trap = 1'b0;
      n.tmo  = 1'b0;
      if (s.drain) begin
         n.waited = s.waited + 1;
         if (mem_idle || n.waited == limit) begin
            n.pc    = s.succ;
            n.drain = 1'b0;
            n.tmo   = !mem_idle;
         end
      end else if (!stall) begin
         if (fence) begin
            n.pred   = s.pc;
            n.succ   = s.pc + 32'd4;
            n.drain  = 1'b1;
            n.waited = 0;
         end else begin
            tk  = m_taken(s);
            tgt = (jump && jalr_sel) ? {alu_target[31:1], 1'b0} : (tk ? s.pc + imm : s.pc + 32'd4);
            if (tk && (tgt % 32'(ialign / 8)) != 32'd0) begin
               n.pc   = TRAP;
               n.trap = 1'b1;
            end else begin
               n.pc = tgt;
            end
         end
      end
      return n;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_model();
      chk("a.pc_out", a_pc, ma.pc);
      chk("a.next_pc", a_next, ma.pc + 32'd4);
      chk("a.taken", 32'(a_taken), 32'(m_taken(ma)));
      chk("a.fence_busy", 32'(a_busy), 32'(ma.drain));
      chk("a.fence_timeout", 32'(a_tmo), 32'(ma.tmo));
      chk("a.misalign_trap", 32'(a_trap), 32'(ma.trap));
      chk("a.predecessor", a_pred, ma.pred);
      chk("a.successor", a_succ, ma.succ);
      chk("b.pc_out", b_pc, mb.pc);
      chk("b.next_pc", b_next, mb.pc + 32'd4);
      chk("b.taken", 32'(b_taken), 32'(m_taken(mb)));
      chk("b.fence_busy", 32'(b_busy), 32'(mb.drain));
      chk("b.fence_timeout", 32'(b_tmo), 32'(mb.tmo));
      chk("b.misalign_trap", 32'(b_trap), 32'(mb.trap));
      chk("b.predecessor", b_pred, mb.pred);
      chk("b.successor", b_succ, mb.succ);
   endtask

   // One clock transaction: check at the falling edge, advance the model on the rising edge.
   task automatic step();
      @(negedge clk);
      chk_model();
      busy_a_n += int'(a_busy);
      busy_b_n += int'(b_busy);
      tmo_a_n  += int'(a_tmo);
      tmo_b_n  += int'(b_tmo);
      $display("cyc %0d pc_a=%h pc_b=%h taken=%b%b busy=%b%b trap=%b%b tmo=%b%b",
               cyc, a_pc, b_pc, a_taken, b_taken, a_busy, b_busy, a_trap, b_trap, a_tmo, b_tmo);
      @(posedge clk);
      if (reset) begin
         ma = m_step(ma, 32, 64);
         mb = m_step(mb, 16, 4);
      end else begin
         ma = m_reset();
         mb = m_reset();
      end
      cyc++;
      #1;
   endtask

   task automatic clear_in();
      stall = 1'b0; branch = 1'b0; jump = 1'b0; jalr_sel = 1'b0; funct3 = 3'b000;
      zero = 1'b0; less_than = 1'b0; less_than_u = 1'b0; imm = 32'h0; alu_target = 32'h0;
      fence = 1'b0; mem_idle = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [3:0]  ctl;     // {stall, branch, jump, jalr_sel}
      logic [2:0]  f3;
      logic [2:0]  flags;   // {zero, less_than, less_than_u}
      logic [31:0] im;
      logic [31:0] alu;
      logic [1:0]  fi;      // {fence, mem_idle}
      logic        exp_taken;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic        exp_trap_a;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic [3:0] ctl, input logic [2:0] f3, input logic [2:0] flags,
                               input logic [31:0] im, input logic [31:0] alu, input logic [1:0] fi,
                               input logic et, input logic [31:0] ea, input logic [31:0] eb,
                               input logic etr);
      vec_t v;
      v.ctl = ctl; v.f3 = f3; v.flags = flags; v.im = im; v.alu = alu; v.fi = fi;
      v.exp_taken = et; v.exp_a = ea; v.exp_b = eb; v.exp_trap_a = etr;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(4'b0000, 3'b000, 3'b000, 32'h0,        32'h0,   2'b00, 1'b0, 32'h4,   32'h4,   1'b0);
      tbl[1]  = mk(4'b0000, 3'b000, 3'b000, 32'h0,        32'h0,   2'b00, 1'b0, 32'h8,   32'h8,   1'b0);
      tbl[2]  = mk(4'b0000, 3'b000, 3'b000, 32'h0,        32'h0,   2'b00, 1'b0, 32'hC,   32'hC,   1'b0);
      tbl[3]  = mk(4'b0010, 3'b000, 3'b000, 32'hF4,       32'h0,   2'b00, 1'b1, 32'h100, 32'h100, 1'b0);
      tbl[4]  = mk(4'b0100, 3'b110, 3'b001, 32'h40,       32'h0,   2'b00, 1'b1, 32'h140, 32'h140, 1'b0);
      tbl[5]  = mk(4'b0010, 3'b000, 3'b000, 32'hFFFF_FFC0, 32'h0,  2'b00, 1'b1, 32'h100, 32'h100, 1'b0);
      tbl[6]  = mk(4'b0100, 3'b010, 3'b001, 32'h40,       32'h0,   2'b00, 1'b0, 32'h104, 32'h104, 1'b0);
      tbl[7]  = mk(4'b0010, 3'b000, 3'b000, 32'hFC,       32'h0,   2'b00, 1'b1, 32'h200, 32'h200, 1'b0);
      tbl[8]  = mk(4'b0011, 3'b000, 3'b000, 32'h0,        32'h333, 2'b00, 1'b1, TRAP,    32'h332, 1'b1);
      tbl[9]  = mk(4'b0000, 3'b000, 3'b000, 32'h0,        32'h0,   2'b00, 1'b0, 32'h14,  32'h336, 1'b0);
      tbl[10] = mk(4'b0100, 3'b000, 3'b100, 32'h2,        32'h0,   2'b00, 1'b1, TRAP,    32'h338, 1'b1);
      tbl[11] = mk(4'b0100, 3'b001, 3'b100, 32'h100,      32'h0,   2'b00, 1'b0, 32'h14,  32'h33C, 1'b0);
      tbl[12] = mk(4'b0100, 3'b100, 3'b010, 32'h8,        32'h0,   2'b00, 1'b1, 32'h1C,  32'h344, 1'b0);
      tbl[13] = mk(4'b0100, 3'b101, 3'b010, 32'h8,        32'h0,   2'b00, 1'b0, 32'h20,  32'h348, 1'b0);
      tbl[14] = mk(4'b0100, 3'b111, 3'b000, 32'h10,       32'h0,   2'b00, 1'b1, 32'h30,  32'h358, 1'b0);
      tbl[15] = mk(4'b1010, 3'b000, 3'b000, 32'h40,       32'h0,   2'b00, 1'b1, 32'h30,  32'h358, 1'b0);
      tbl[16] = mk(4'b0010, 3'b000, 3'b000, 32'h40,       32'h0,   2'b10, 1'b0, 32'h30,  32'h358, 1'b0);
      tbl[17] = mk(4'b0010, 3'b000, 3'b000, 32'h40,       32'h0,   2'b01, 1'b0, 32'h34,  32'h35C, 1'b0);

      // Reset state
      clear_in();
      reset = 1'b0;
      ma = m_reset();
      mb = m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.pc_a", a_pc, 32'h0);
      chk("rst.pc_b", b_pc, 32'h0);
      chk("rst.busy_a", 32'(a_busy), 32'h0);
      chk("rst.trap_a", 32'(a_trap), 32'h0);
      chk("rst.tmo_a", 32'(a_tmo), 32'h0);
      reset = 1'b1;

      // Table: one row per clock, expected pc_out after the edge
      for (int i = 0; i < 18; i++) begin
         {stall, branch, jump, jalr_sel} = tbl[i].ctl;
         funct3 = tbl[i].f3;
         {zero, less_than, less_than_u} = tbl[i].flags;
         imm = tbl[i].im;
         alu_target = tbl[i].alu;
         {fence, mem_idle} = tbl[i].fi;
         #1;
         chk($sformatf("tbl%0d.taken_a", i), 32'(a_taken), 32'(tbl[i].exp_taken));
         chk($sformatf("tbl%0d.taken_b", i), 32'(b_taken), 32'(tbl[i].exp_taken));
         step();
         chk($sformatf("tbl%0d.pc_a", i), a_pc, tbl[i].exp_a);
         chk($sformatf("tbl%0d.pc_b", i), b_pc, tbl[i].exp_b);
         chk($sformatf("tbl%0d.trap_a", i), 32'(a_trap), 32'(tbl[i].exp_trap_a));
      end
      chk("tbl.pred_a", a_pred, 32'h30);
      chk("tbl.succ_a", a_succ, 32'h34);
      chk("tbl.pred_b", b_pred, 32'h358);
      chk("tbl.succ_b", b_succ, 32'h35C);

      // Fence at 0x80: a drains 6 cycles (idle on 6th), b times out after 4; stall ignored
      clear_in();
      jump = 1'b1; jalr_sel = 1'b1; alu_target = 32'h80;
      step();
      chk("fence.start_a", a_pc, 32'h80);
      clear_in();
      fence = 1'b1;
      step();
      fence = 1'b0;
      busy_a_n = 0; busy_b_n = 0; tmo_a_n = 0; tmo_b_n = 0;
      for (int k = 0; k < 8; k++) begin
         stall = 1'b1;
         mem_idle = (k == 5);
         step();
      end
      chk("fence.busy_cycles_a", 32'(busy_a_n), 32'd6);
      chk("fence.busy_cycles_b", 32'(busy_b_n), 32'd4);
      chk("fence.tmo_pulses_a", 32'(tmo_a_n), 32'd0);
      chk("fence.tmo_pulses_b", 32'(tmo_b_n), 32'd1);
      chk("fence.pc_a", a_pc, 32'h84);
      chk("fence.pc_b", b_pc, 32'h84);
      chk("fence.pred_a", a_pred, 32'h80);
      chk("fence.succ_a", a_succ, 32'h84);

      // Asynchronous reset in the middle of DRAIN
      clear_in();
      fence = 1'b1;
      step();
      fence = 1'b0;
      step();
      #1 reset = 1'b0;
      ma = m_reset();
      mb = m_reset();
      #1;
      chk("rstdrain.pc_a", a_pc, 32'h0);
      chk("rstdrain.busy_a", 32'(a_busy), 32'h0);
      chk("rstdrain.pred_a", a_pred, 32'h0);
      chk("rstdrain.succ_a", a_succ, 32'h0);
      chk("rstdrain.busy_b", 32'(b_busy), 32'h0);
      #1 reset = 1'b1;
      mem_idle = 1'b1;
      step();
      chk("rstdrain.after_a", a_pc, 32'h4);
      chk("rstdrain.after_b", b_pc, 32'h4);

      // Sequential wrap at the top of the address space
      clear_in();
      jump = 1'b1; jalr_sel = 1'b1; alu_target = 32'hFFFF_FFFC;
      step();
      chk("wrap.pc_a", a_pc, 32'hFFFF_FFFC);
      chk("wrap.next_a", a_next, 32'h0);
      clear_in();
      step();
      chk("wrap.after_a", a_pc, 32'h0);
      chk("wrap.after_b", b_pc, 32'h0);

      // Randomized traffic against the model
      for (int r = 0; r < 300; r++) begin
         stall       = ($urandom_range(0, 7) == 0);
         branch      = $urandom_range(0, 1) == 1;
         jump        = ($urandom_range(0, 3) == 0);
         jalr_sel    = $urandom_range(0, 1) == 1;
         funct3      = 3'($urandom_range(0, 7));
         zero        = $urandom_range(0, 1) == 1;
         less_than   = $urandom_range(0, 1) == 1;
         less_than_u = $urandom_range(0, 1) == 1;
         imm         = 32'($urandom_range(0, 255)) - 32'd128;
         alu_target  = $urandom();
         fence       = ($urandom_range(0, 9) == 0);
         mem_idle    = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
